lcd_16207_sequencer: RTL and testbench

- Avalon-MM master that sits directly upstream of the 16207 character-LCD Avalon slave.
- Accepts instruction/data bytes through a ready/valid stream and buffers them in a small FIFO.
- Drives the slave's address/read/write/writedata signals with HD44780-compliant setup, E-high and hold timing.
- After every write, polls the busy flag (BF) so that software or hardware producers never handle LCD timing.

---
 rtl/lcd_16207_sequencer.sv | 130 +++++++++++++
 tb/tb_lcd_16207_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_16207_sequencer.sv
// lcd_16207_sequencer: buffers ready/valid LCD bytes and plays them to the 16207 Avalon slave with HD44780 timing and BF polling.
// Define LCD_SEQ_INIT_EN to run the power-on wait and the 0x38/0x0C/0x01/0x06 init sequence before accepting FIFO traffic.
module lcd_16207_sequencer #(
  parameter int FIFO_DEPTH    = 16,
  parameter int SETUP_CYCLES  = 3,
  parameter int E_HIGH_CYCLES = 25,
  parameter int HOLD_CYCLES   = 2,
  parameter int BUSY_TIMEOUT  = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic [1:0] lcd_address,
  output logic       lcd_read,
  output logic       lcd_write,
  output logic       lcd_begintransfer,
  output logic [7:0] lcd_writedata,
  input  logic [7:0] lcd_readdata,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clear
);
`ifdef LCD_SEQ_INIT_EN
  localparam bit INIT_EN     = 1'b1;
  localparam int INIT_CYCLES = 750000;
`else
  localparam bit INIT_EN     = 1'b0;
  localparam int INIT_CYCLES = 1;
`endif
  localparam int M1   = SETUP_CYCLES > E_HIGH_CYCLES ? SETUP_CYCLES : E_HIGH_CYCLES;
  localparam int M2   = HOLD_CYCLES > BUSY_TIMEOUT ? HOLD_CYCLES : BUSY_TIMEOUT;
  localparam int M3   = M1 > M2 ? M1 : M2;
  localparam int MAXP = M3 > INIT_CYCLES ? M3 : INIT_CYCLES;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] S_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] E_LAST = CW'(E_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] I_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] T_MAX  = CW'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {IDLE, W_SETUP, W_EHIGH, W_HOLD, B_SETUP, B_EHIGH, B_HOLD, INIT_WAIT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, tcnt, lim;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [8:0]    head, src;
  logic [7:0]    init_byte;
  logic [2:0]    init_idx;
  logic          ready_en, bf, empty, full, push, pop, init_pend, load, last, tmo_hit, in_poll;

  always_comb begin
    empty     = wr_ptr == rd_ptr;
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    cmd_ready = ready_en && !full;
    push      = cmd_valid && cmd_ready;
    init_pend = init_idx != 3'd4;
    load      = state == IDLE && (init_pend || !empty);
    pop       = load && !init_pend;
    head      = mem[rd_ptr[AW-1:0]];
    init_byte = init_idx == 3'd0 ? 8'h38 : init_idx == 3'd1 ? 8'h0C : init_idx == 3'd2 ? 8'h01 : 8'h06;
    src       = init_pend ? {1'b0, init_byte} : head;
    lim       = (state == W_SETUP || state == B_SETUP) ? S_LAST :
                (state == W_EHIGH || state == B_EHIGH) ? E_LAST :
                (state == W_HOLD  || state == B_HOLD)  ? H_LAST : I_LAST;
    last      = cnt == lim;
    in_poll   = state == B_SETUP || state == B_EHIGH || state == B_HOLD;
    tmo_hit   = state == B_HOLD && last && bf && tcnt >= T_MAX;
    state_n   = state;
    case (state)
      IDLE:      state_n = load ? W_SETUP : IDLE;
      W_SETUP:   state_n = last ? W_EHIGH : W_SETUP;
      W_EHIGH:   state_n = last ? W_HOLD : W_EHIGH;
      W_HOLD:    state_n = last ? B_SETUP : W_HOLD;
      B_SETUP:   state_n = last ? B_EHIGH : B_SETUP;
      B_EHIGH:   state_n = last ? B_HOLD : B_EHIGH;
      B_HOLD:    state_n = !last ? B_HOLD : (bf && !tmo_hit) ? B_SETUP : IDLE;
      INIT_WAIT: state_n = last ? IDLE : INIT_WAIT;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_rs, cmd_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= INIT_EN ? INIT_WAIT : IDLE;
      init_idx          <= INIT_EN ? 3'd0 : 3'd4;
      cnt               <= '0;
      tcnt              <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      ready_en          <= 1'b0;
      bf                <= 1'b0;
      lcd_address       <= 2'b00;
      lcd_writedata     <= 8'h00;
      lcd_read          <= 1'b0;
      lcd_write         <= 1'b0;
      lcd_begintransfer <= 1'b0;
      timeout_err       <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
      ready_en          <= 1'b1;
      wr_ptr            <= wr_ptr + {{AW{1'b0}}, push};
      rd_ptr            <= rd_ptr + {{AW{1'b0}}, pop};
      if (load && init_pend) init_idx <= init_idx + 3'd1;
      if (load) begin
        lcd_address   <= {src[8], 1'b0};
        lcd_writedata <= src[7:0];
      end else if (state == W_HOLD && last) lcd_address <= 2'b01;
      else if (state == B_HOLD && state_n == IDLE) lcd_address <= 2'b00;
      lcd_write         <= state_n == W_EHIGH;
      lcd_read          <= state_n == B_EHIGH;
      lcd_begintransfer <= state_n != state && (state_n == W_EHIGH || state_n == B_EHIGH);
      if (state == B_EHIGH && last) bf <= lcd_readdata[7];
      if (state == W_HOLD && last) tcnt <= '0;
      else if (in_poll && tcnt != T_MAX) tcnt <= tcnt + 1'b1;
      timeout_err       <= tmo_hit || (timeout_err && !err_clear);
      busy              <= state != IDLE || !empty || init_pend;
    end
  end
endmodule

// File: tb/tb_lcd_16207_sequencer.sv
// tb_lcd_16207_sequencer: directed checks of write timing, BF polling, timeout, FIFO backpressure and async reset.
module tb_lcd_16207_sequencer;
  logic       clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, cmd_rs = 1'b0, err_clear = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, lcd_read, lcd_write, lcd_begintransfer, busy, timeout_err;
  logic [1:0] lcd_address;
  logic [7:0] lcd_writedata, lcd_readdata;
  int         checks = 0, failures = 0;
  int         rd_cnt = 0, rd_base = 0, overlap = 0, mode = 0;
  logic [7:0] wlog [$];

  always #5 clk = ~clk;

  lcd_16207_sequencer #(
    .FIFO_DEPTH(4), .SETUP_CYCLES(3), .E_HIGH_CYCLES(4), .HOLD_CYCLES(2), .BUSY_TIMEOUT(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs),
    .cmd_data(cmd_data), .lcd_address(lcd_address), .lcd_read(lcd_read), .lcd_write(lcd_write),
    .lcd_begintransfer(lcd_begintransfer), .lcd_writedata(lcd_writedata), .lcd_readdata(lcd_readdata),
    .busy(busy), .timeout_err(timeout_err), .err_clear(err_clear)
  );

  // mode 0: never busy, 1: busy for two polls then ready, 2: stuck busy
  assign lcd_readdata = mode == 0 ? 8'h00 : mode == 2 ? 8'h80 : (rd_cnt - rd_base <= 2) ? 8'h80 : 8'h05;

  always @(posedge clk) begin
    if (lcd_read && lcd_begintransfer) rd_cnt <= rd_cnt + 1;
    if (lcd_write && lcd_begintransfer) wlog.push_back(lcd_writedata);
    if (lcd_read && lcd_write) overlap <= overlap + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_rs = rs;
    cmd_data = d;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_ready: cmd_ready=%b expected 1", cmd_ready);
    end
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    #1;
    v = {lcd_address, lcd_read, lcd_write, lcd_begintransfer, lcd_writedata, busy, timeout_err, cmd_ready};
    checks++;
    if (v !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0000", v);
    end
    tick(2);
    reset_n = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_at_release: got %b expected 0", cmd_ready);
    end
    tick(1);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_release: ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_single_write;
    logic [12:0] exp_v, act_v;
    mode = 0;
    push(1'b1, 8'h41);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      exp_v = {k <= 9 ? 2'b10 : k <= 18 ? 2'b01 : 2'b00, k >= 4 && k <= 7, k >= 13 && k <= 16,
               k == 4 || k == 13, k <= 19, 8'h41};
      act_v = {lcd_address, lcd_write, lcd_read, lcd_begintransfer, busy, lcd_writedata};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL single_write_cycle%0d: got {addr,wr,rd,bt,busy,wd}=%b expected %b", k, act_v, exp_v);
      end
    end
  endtask

  task automatic test_bf_poll;
    int i;
    mode = 1;
    rd_base = rd_cnt;
    push(1'b0, 8'h01);
    for (i = 0; i < 300; i++) begin
      tick(1);
      if (!busy && i > 2) break;
    end
    checks++;
    if (busy !== 1'b0 || rd_cnt - rd_base != 3 || timeout_err !== 1'b0 || lcd_address !== 2'b00) begin
      failures++;
      $display("FAIL bf_poll: busy=%b polls=%0d tmo=%b addr=%b expected 0 3 0 00",
               busy, rd_cnt - rd_base, timeout_err, lcd_address);
    end
    checks++;
    if (wlog.size() == 0 || wlog[wlog.size()-1] !== 8'h01) begin
      failures++;
      $display("FAIL bf_poll_data: log size %0d expected last byte 01", wlog.size());
    end
    mode = 0;
  endtask

  task automatic test_timeout;
    int n0;
    mode = 2;
    rd_base = rd_cnt;
    n0 = wlog.size();
    push(1'b0, 8'h51);
    push(1'b0, 8'h52);
    for (int i = 0; i < 300 && !timeout_err; i++) tick(1);
    checks++;
    if (timeout_err !== 1'b1 || rd_cnt - rd_base != 3) begin
      failures++;
      $display("FAIL timeout_set: tmo=%b polls=%0d expected 1 3", timeout_err, rd_cnt - rd_base);
    end
    for (int i = 0; i < 50 && wlog.size() < n0 + 2; i++) tick(1);
    checks++;
    if (wlog.size() != n0 + 2 || wlog[n0+1] !== 8'h52 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_next: writes=%0d tmo=%b expected %0d writes, second 52, tmo 1",
               wlog.size() - n0, timeout_err, 2);
    end
    mode = 0;
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: tmo=%b expected 0", timeout_err);
    end
    for (int i = 0; i < 300 && busy; i++) tick(1);
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_drain: busy=%b tmo=%b expected 0 0", busy, timeout_err);
    end
  endtask

  task automatic test_fifo_full;
    int acc = 0, n0;
    mode = 2;
    n0 = wlog.size();
    for (int i = 0; i < 12; i++) begin
      cmd_valid = 1'b1;
      cmd_rs = 1'b0;
      cmd_data = 8'h10 + 8'(acc);
      if (!cmd_ready) break;
      tick(1);
      acc++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (acc != 5) begin
      failures++;
      $display("FAIL fifo_accepts: got %0d expected 5", acc);
    end
    tick(3);
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL fifo_ready_low: got %b expected 0", cmd_ready);
    end
    mode = 0;
    for (int i = 0; i < 1000 && busy; i++) tick(1);
    checks++;
    if (busy !== 1'b0 || wlog.size() != n0 + 5) begin
      failures++;
      $display("FAIL fifo_drain: busy=%b writes=%0d expected 0 5", busy, wlog.size() - n0);
    end
    for (int i = 0; i < 5 && n0 + i < wlog.size(); i++) begin
      checks++;
      if (wlog[n0+i] !== 8'h10 + 8'(i)) begin
        failures++;
        $display("FAIL fifo_order%0d: got %h expected %h", i, wlog[n0+i], 8'h10 + 8'(i));
      end
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    logic [3:0] v;
    mode = 0;
    push(1'b1, 8'hA1);
    push(1'b1, 8'hA2);
    for (int i = 0; i < 30 && !lcd_write; i++) tick(1);
    checks++;
    if (lcd_write !== 1'b1) begin
      failures++;
      $display("FAIL mid_reach_ehigh: write=%b expected 1", lcd_write);
    end
    #2 reset_n = 1'b0;
    #1;
    v = {lcd_write, lcd_address, lcd_begintransfer};
    checks++;
    if (v !== 4'b0) begin
      failures++;
      $display("FAIL mid_async_reset: got {wr,addr,bt}=%b expected 0000", v);
    end
    tick(1);
    reset_n = 1'b1;
    n0 = wlog.size();
    tick(40);
    checks++;
    if (busy !== 1'b0 || wlog.size() != n0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_flush: busy=%b new_writes=%0d ready=%b expected 0 0 1", busy, wlog.size() - n0, cmd_ready);
    end
  endtask

  task automatic test_no_overlap;
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL rd_wr_overlap: got %0d cycles expected 0", overlap);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_bf_poll;
    test_timeout;
    test_fifo_full;
    test_reset_mid;
    test_no_overlap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
